// File: rtl/alu_exec_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_exec_stage_pkg
// Shared definitions for the execute-stage slice: default widths and the
// 3-bit ALU operation codes decoded by alu_core.
// Optional feature macro used elsewhere in this slice: ALU_OVF_EN.
// -----------------------------------------------------------------------------
package alu_exec_stage_pkg;

    localparam int DEF_DW = 32;   // datapath width
    localparam int DEF_RW = 5;    // register-index / shamt width

    typedef logic [2:0] aluOp_t;

    localparam aluOp_t ALU_AND = 3'b000;
    localparam aluOp_t ALU_OR  = 3'b001;
    localparam aluOp_t ALU_ADD = 3'b010;
    localparam aluOp_t ALU_SLL = 3'b011;
    localparam aluOp_t ALU_SRL = 3'b100;
    localparam aluOp_t ALU_SRA = 3'b101;
    localparam aluOp_t ALU_SUB = 3'b110;
    localparam aluOp_t ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_exec_stage_if.sv
// -----------------------------------------------------------------------------
// alu_exec_stage_if
// Bundles the execute-stage control, operand and result signals.
//   master : decode side; drives controls/operands, observes results.
//   slave  : the execute stage; consumes controls/operands, drives results.
// Signals:
//   alu_src, reg_dst, alu_control, rt, rd, shamt, src_a, rd2, sign_imm (to EX)
//   alu_out_e, zero_e (combinational), alu_out_m, zero_m, write_data_m,
//   write_reg_m (registered EX/MEM outputs)
// Optional (macro ALU_OVF_EN): ovf_e, ovf_m signed-overflow flags.
// -----------------------------------------------------------------------------
interface alu_exec_stage_if
    import alu_exec_stage_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int RW = DEF_RW
) ();

    logic          alu_src;
    logic          reg_dst;
    aluOp_t        alu_control;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [RW-1:0] shamt;
    logic [DW-1:0] src_a;
    logic [DW-1:0] rd2;
    logic [DW-1:0] sign_imm;

    logic [DW-1:0] alu_out_e;
    logic          zero_e;
    logic [DW-1:0] alu_out_m;
    logic          zero_m;
    logic [DW-1:0] write_data_m;
    logic [RW-1:0] write_reg_m;
`ifdef ALU_OVF_EN
    logic          ovf_e;
    logic          ovf_m;
`endif

    modport master (
        output alu_src, reg_dst, alu_control, rt, rd, shamt, src_a, rd2, sign_imm,
        input  alu_out_e, zero_e, alu_out_m, zero_m, write_data_m, write_reg_m
`ifdef ALU_OVF_EN
        , input ovf_e, ovf_m
`endif
    );

    modport slave (
        input  alu_src, reg_dst, alu_control, rt, rd, shamt, src_a, rd2, sign_imm,
        output alu_out_e, zero_e, alu_out_m, zero_m, write_data_m, write_reg_m
`ifdef ALU_OVF_EN
        , output ovf_e, ovf_m
`endif
    );

endinterface

// File: rtl/alu_exec_stage_alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU: AND/OR/ADD/SUB/SLT plus SLL/SRL/SRA by shamt.
// Ports:
//   a, b    : operands (shifts operate on b only)
//   op      : 3-bit operation code (see alu_exec_stage_pkg)
//   shamt   : shift amount
//   result  : operation result
//   zero    : result == 0
//   ovf     : signed overflow of ADD/SUB, 0 otherwise (macro ALU_OVF_EN)
// -----------------------------------------------------------------------------
module alu_core
    import alu_exec_stage_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int RW = DEF_RW
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  aluOp_t        op,
    input  logic [RW-1:0] shamt,
    output logic [DW-1:0] result,
    output logic          zero
`ifdef ALU_OVF_EN
    , output logic        ovf
`endif
);

    logic [DW-1:0] sum;
    logic [DW-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        // NOTE: a default before the case keeps this block latch-free even if
        // an op code is added later without a matching branch.
        result = '0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = sum;
            ALU_SUB: result = diff;
            // True signed compare, so overflow in a - b cannot flip the answer.
            ALU_SLT: result = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL: result = b << shamt;
            ALU_SRL: result = b >> shamt;
            ALU_SRA: result = $unsigned($signed(b) >>> shamt);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

`ifdef ALU_OVF_EN
    always_comb begin
        ovf = 1'b0;
        case (op)
            ALU_ADD: ovf = (a[DW-1] == b[DW-1]) && (sum[DW-1]  != a[DW-1]);
            ALU_SUB: ovf = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
            default: ovf = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
// Execute-stage datapath slice: selects ALU operand B and the destination
// register, runs alu_core, and registers the results into the EX/MEM boundary
// every cycle (no stall or flush).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears every *_m output
//   bus   : alu_exec_stage_if.slave (controls, operands, results)
// Optional feature macro: ALU_OVF_EN adds ovf_e / ovf_m.
// -----------------------------------------------------------------------------
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int RW = DEF_RW
) (
    input  logic            clk,
    input  logic            reset,
    alu_exec_stage_if.slave bus
);

    logic [DW-1:0] srcB;
    logic [RW-1:0] writeRegE;
    logic [DW-1:0] aluResult;
    logic          aluZero;

    assign srcB      = bus.alu_src ? bus.sign_imm : bus.rd2;
    assign writeRegE = bus.reg_dst ? bus.rd : bus.rt;

`ifdef ALU_OVF_EN
    logic aluOvf;
`endif

    alu_core #(
        .DW (DW),
        .RW (RW)
    ) uAluCore (
        .a      (bus.src_a),
        .b      (srcB),
        .op     (bus.alu_control),
        .shamt  (bus.shamt),
        .result (aluResult),
        .zero   (aluZero)
`ifdef ALU_OVF_EN
        , .ovf  (aluOvf)
`endif
    );

    assign bus.alu_out_e = aluResult;
    assign bus.zero_e    = aluZero;

    // NOTE: non-blocking assignments here so every pipeline register samples
    // pre-edge values; the asynchronous reset is what lets a mid-cycle pulse
    // drop the in-flight result immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.alu_out_m    <= '0;
            bus.zero_m       <= 1'b0;
            bus.write_data_m <= '0;
            bus.write_reg_m  <= '0;
        end else begin
            bus.alu_out_m    <= aluResult;
            bus.zero_m       <= aluZero;
            bus.write_data_m <= bus.rd2;
            bus.write_reg_m  <= writeRegE;
        end
    end

`ifdef ALU_OVF_EN
    assign bus.ovf_e = aluOvf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) bus.ovf_m <= 1'b0;
        else       bus.ovf_m <= aluOvf;
    end
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_stage
// Self-checking bench for alu_exec_stage. A driver applies one operation per
// cycle on the falling edge and queues the expected response; a monitor pops
// one entry after each rising edge and compares both the combinational and
// the registered outputs. Expected values come from an arithmetic reference
// model (64-bit signed math for SLT/overflow, wide shifts for SRA).
// Optional feature macro: ALU_OVF_EN (overflow flags also checked).
// -----------------------------------------------------------------------------
module tb_alu_exec_stage;
    import alu_exec_stage_pkg::*;

    typedef struct packed {
        logic [31:0] aluOut;
        logic        zero;
        logic [31:0] writeData;
        logic [4:0]  writeReg;
        logic        ovf;
    } expect_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    expect_t sb[$];

    alu_exec_stage_if #(.DW(32), .RW(5)) bus ();

    alu_exec_stage #(.DW(32), .RW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: computed from the operation definitions with wide math.
    function automatic logic [31:0] refAlu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh,
                                           output logic ovf);
        longint     sa;
        longint     sbv;
        longint     wide;
        logic [63:0] ext;
        logic [31:0] r;
        sa   = $signed(a);
        sbv  = $signed(b);
        ovf  = 1'b0;
        r    = 32'h0;
        wide = 0;
        ext  = 64'h0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                wide = sa + sbv;
                r    = wide[31:0];
                ovf  = (wide > 64'sh7FFF_FFFF) || (wide < -64'sh8000_0000);
            end
            3'b110: begin
                wide = sa - sbv;
                r    = wide[31:0];
                ovf  = (wide > 64'sh7FFF_FFFF) || (wide < -64'sh8000_0000);
            end
            3'b111: r = (sa < sbv) ? 32'd1 : 32'd0;
            3'b011: r = b << sh;
            3'b100: r = b >> sh;
            default: begin
                ext = {{32{b[31]}}, b};
                ext = ext >> sh;
                r   = ext[31:0];
            end
        endcase
        return r;
    endfunction

    task automatic issue(input logic aSrc, input logic rDst, input logic [2:0] op,
                         input logic [4:0] rtV, input logic [4:0] rdV, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] r2, input logic [31:0] imm);
        expect_t e;
        logic    ov;
        @(negedge clk);
        bus.alu_src     = aSrc;
        bus.reg_dst     = rDst;
        bus.alu_control = op;
        bus.rt          = rtV;
        bus.rd          = rdV;
        bus.shamt       = sh;
        bus.src_a       = a;
        bus.rd2         = r2;
        bus.sign_imm    = imm;
        e.aluOut    = refAlu(op, a, aSrc ? imm : r2, sh, ov);
        e.zero      = (e.aluOut == 32'h0);
        e.writeData = r2;
        e.writeReg  = rDst ? rdV : rtV;
        e.ovf       = ov;
        sb.push_back(e);
    endtask

    task automatic checkRegsCleared(input string tag);
        check({tag, "_alu_out_m"},    {32'h0, bus.alu_out_m},    64'h0);
        check({tag, "_zero_m"},       {63'h0, bus.zero_m},       64'h0);
        check({tag, "_write_data_m"}, {32'h0, bus.write_data_m}, 64'h0);
        check({tag, "_write_reg_m"},  {59'h0, bus.write_reg_m},  64'h0);
`ifdef ALU_OVF_EN
        check({tag, "_ovf_m"},        {63'h0, bus.ovf_m},        64'h0);
`endif
    endtask

    function automatic logic [31:0] randWord();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'($urandom_range(0, 3));
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: registered and combinational outputs both reflect the entry
    // queued on the preceding falling edge.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("alu_out_e",    {32'h0, bus.alu_out_e},    {32'h0, e.aluOut});
                check("zero_e",       {63'h0, bus.zero_e},       {63'h0, e.zero});
                check("alu_out_m",    {32'h0, bus.alu_out_m},    {32'h0, e.aluOut});
                check("zero_m",       {63'h0, bus.zero_m},       {63'h0, e.zero});
                check("write_data_m", {32'h0, bus.write_data_m}, {32'h0, e.writeData});
                check("write_reg_m",  {59'h0, bus.write_reg_m},  {59'h0, e.writeReg});
`ifdef ALU_OVF_EN
                check("ovf_e",        {63'h0, bus.ovf_e},        {63'h0, e.ovf});
                check("ovf_m",        {63'h0, bus.ovf_m},        {63'h0, e.ovf});
`endif
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.alu_src = 1'b0; bus.reg_dst = 1'b0; bus.alu_control = 3'b000;
        bus.rt = '0; bus.rd = '0; bus.shamt = '0;
        bus.src_a = '0; bus.rd2 = '0; bus.sign_imm = '0;
        #2;
        checkRegsCleared("reset");
        @(negedge clk);
        reset = 1'b0;

        // Directed cases
        issue(0, 0, ALU_ADD, 5'd3, 5'd9, 5'd0, 32'd5, 32'd3, 32'd0);
        issue(1, 1, ALU_SUB, 5'd3, 5'd9, 5'd0, 32'd7, 32'd1, 32'd7);
        issue(0, 0, ALU_SLT, 5'd1, 5'd2, 5'd0, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0);
        issue(0, 0, ALU_SLT, 5'd1, 5'd2, 5'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0);
        issue(0, 0, ALU_SLT, 5'd1, 5'd2, 5'd0, 32'h1234_5678, 32'h1234_5678, 32'd0);
        issue(0, 0, ALU_SLL, 5'd0, 5'd0, 5'd4, 32'hDEAD_BEEF, 32'h8000_0010, 32'd0);
        issue(0, 0, ALU_SRL, 5'd0, 5'd0, 5'd4, 32'hDEAD_BEEF, 32'h8000_0010, 32'd0);
        issue(0, 0, ALU_SRA, 5'd0, 5'd0, 5'd4, 32'hDEAD_BEEF, 32'h8000_0010, 32'd0);
        issue(0, 0, ALU_SLL, 5'd0, 5'd0, 5'd0, 32'hDEAD_BEEF, 32'h8000_0010, 32'd0);
        issue(0, 0, ALU_SRA, 5'd0, 5'd0, 5'd0, 32'hDEAD_BEEF, 32'h8000_0010, 32'd0);
        issue(0, 0, ALU_AND, 5'd0, 5'd0, 5'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0);
        issue(0, 0, ALU_OR,  5'd0, 5'd0, 5'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0);
        issue(0, 1, ALU_ADD, 5'd3, 5'd9, 5'd0, 32'h7FFF_FFFF, 32'd1, 32'd0);
        issue(0, 0, ALU_SUB, 5'd3, 5'd9, 5'd0, 32'h8000_0000, 32'd1, 32'd0);

        // Reset pulsed between edges discards the in-flight value; the next
        // edge after release captures normally.
        issue(0, 1, ALU_OR, 5'd3, 5'd9, 5'd0, 32'h1111_0000, 32'h0000_2222, 32'd0);
        #2 reset = 1'b1;
        #1 checkRegsCleared("midreset");
        #1 reset = 1'b0;

        // Randomized cases
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [31:0] r2;
            a  = randWord();
            r2 = ($urandom_range(0, 7) == 0) ? a : randWord();
            issue(1'($urandom), 1'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), a, r2, randWord());
        end

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #3;
        check("scoreboard_drain", 64'(sb.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage datapath slice for the pipelined MIPS CPU.
- Selects the ALU B operand (register value or sign-extended immediate) and the destination register (rt or rd).
- Performs a 3-bit-coded ALU operation with a 5-bit shift amount.
- Registers result, zero flag, store data and destination register into the EX/MEM boundary.

Parameters:
- DW, 32, datapath width in bits.
- RW, 5, register-index width; also the shamt width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all output registers.
- alu_src  in  1  0: B=rd2; 1: B=sign_imm.
- reg_dst  in  1  0: dest=rt; 1: dest=rd.
- alu_control  in  3  operation code.
- rt  in  RW  rt field.
- rd  in  RW  rd field.
- shamt  in  RW  shift amount.
- src_a  in  DW  A operand.
- rd2  in  DW  register B value; also the store data.
- sign_imm  in  DW  sign-extended immediate.
- alu_out_e  out  DW  combinational ALU result.
- zero_e  out  1  combinational: alu_out_e == 0.
- alu_out_m  out  DW  registered result.
- zero_m  out  1  registered zero flag.
- write_data_m  out  DW  registered rd2.
- write_reg_m  out  RW  registered destination index.

Behaviour:
- Operand B mux (2:1, DW): srcB = alu_src ? sign_imm : rd2.
- Dest mux (2:1, RW): write_reg_e = reg_dst ? rd : rt.
- ALU op codes:
  - 000 AND: A & B.
  - 001 OR: A | B.
  - 010 ADD: A + B, modulo 2^DW, carry discarded.
  - 110 SUB: A − B, modulo 2^DW.
  - 111 SLT: signed compare; result is 1 if A < B, else 0, zero-extended to DW.
  - 011 SLL: B << shamt.
  - 100 SRL: B >> shamt, logical.
  - 101 SRA: B >>> shamt, arithmetic; sign bit replicated.
- Shifts use only shamt; A is ignored for shift ops. shamt=0 passes B unchanged.
- SLT edge cases:
  - 0x80000000 vs 0x7FFFFFFF gives 1.
  - Equal operands give 0.
  - Uses a true signed comparison, not the sign of the subtraction, so it is correct on overflow.
- zero_e is 1 when alu_out_e is all-zero, for every op.
- Combinational outputs settle within the same cycle; no latches. Every case branch assigns a result.
- Registered outputs: on posedge clk, alu_out_m/zero_m/write_data_m/write_reg_m capture alu_out_e/zero_e/rd2/write_reg_e. Latency is 1 cycle.
- Reset: asserting reset immediately (asynchronously) forces all *_m outputs to 0.
  - Reset asserted mid-operation discards the in-flight value.
  - The first capture after deassert occurs on the next rising edge.
- No stall or flush input; registers load every cycle.

Optional Feature:
- Macro ALU_OVF_EN.
- Defined:
  - Extra outputs ovf_e (combinational) and ovf_m (registered, reset 0).
  - ovf_e is the signed overflow of ADD (operands same sign, result sign differs) or SUB (operands differ in sign, result sign differs from A).
  - ovf_e is 0 for all other ops.
- Undefined: ports absent, all other behaviour identical.

Decomposition:
- Shared package: ALU op-code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA), DW/RW defaults.
- One natural sub-module, alu_core: purely combinational (A, B, op, shamt -> result, zero[, ovf]).
- The two 2:1 muxes stay inline in the top level.

Test Plan:
- src_a=5, rd2=3, alu_src=0, op=010 -> alu_out_e=8, zero_e=0; next edge alu_out_m=8, write_data_m=3.
- src_a=7, sign_imm=7, alu_src=1, op=110 -> alu_out_e=0, zero_e=1; op=111 with src_a=0x80000000, rd2=0x7FFFFFFF, alu_src=0 -> alu_out_e=1.
- rd2=0x80000010, shamt=4: op=011 -> 0x00000100; op=100 -> 0x08000001; op=101 -> 0xF8000001; shamt=0 returns B.
- src_a=0xF0F0F0F0, rd2=0x0FF00FF0: op=000 -> 0x00F000F0, op=001 -> 0xFFF0FFF0.
- rt=3, rd=9: reg_dst=0 -> write_reg_m=3 after edge; reg_dst=1 -> 9.
- Registers loaded with nonzero values, then reset pulsed between edges -> all *_m read 0 before the next edge. With ALU_OVF_EN: 0x7FFFFFFF+1 gives ovf_e=1.
